// File: rtl/hid_multi.sv
// hid_multi: MCU byte-link decoder driving keyboard matrix, joysticks, mouse and DB9 change interrupt.
// Optional build macro HID_MOUSE_ACC_EN turns mouse_x/mouse_y into saturating accumulators.
module hid_multi #(
  parameter int NUM_JOY   = 2,
  parameter int DB9_PORTS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_in_strobe,
  input  logic                     data_in_start,
  input  logic [7:0]               data_in,
  output logic [7:0]               data_out,
  input  logic [6*DB9_PORTS-1:0]   db9_port,
  output logic                     irq,
  input  logic                     iack,
  output logic [8*NUM_JOY-1:0]     joystick,
  output logic [7:0]               numpad,
  output logic                     mod_key,
  output logic                     key_restore,
  output logic                     tape_play,
  input  logic [7:0]               keyboard_matrix_out,
  output logic [7:0]               keyboard_matrix_in,
  output logic [1:0]               mouse_btns,
  output logic [7:0]               mouse_x,
  output logic [7:0]               mouse_y,
  output logic                     mouse_strobe,
  input  logic                     mouse_ack
);

  localparam logic [7:0] CMD_STATUS   = 8'h00;
  localparam logic [7:0] CMD_KEYBOARD = 8'h01;
  localparam logic [7:0] CMD_MOUSE    = 8'h02;
  localparam logic [7:0] CMD_JOYSTICK = 8'h03;
  localparam logic [7:0] CMD_DB9      = 8'h04;
  localparam logic [7:0] DEV_NUMPAD   = 8'h80;

  logic [3:0]                 state_q, state_d;
  logic [7:0]                 command_q, command_d;
  logic [7:0]                 device_q, device_d;
  logic [7:0]                 data_out_q, data_out_d;
  logic [7:0][7:0]            keyboard_q, keyboard_d;
  logic [8*NUM_JOY-1:0]       joystick_q, joystick_d;
  logic [7:0]                 numpad_q, numpad_d;
  logic                       mod_key_q, mod_key_d;
  logic                       key_restore_q, key_restore_d;
  logic                       tape_play_q, tape_play_d;
  logic [1:0]                 mouse_btns_q, mouse_btns_d;
  logic [7:0]                 mouse_x_q, mouse_x_d;
  logic [7:0]                 mouse_y_q, mouse_y_d;
  logic                       mouse_strobe_q, mouse_strobe_d;
  logic                       irq_q, irq_d;
  logic                       irq_enable_q, irq_enable_d;
  logic [1:0]                 pending_q, pending_d;
  logic [6*DB9_PORTS-1:0]     db9_q, db9_d;
  logic [1:0]                 change_s;
  logic [7:0]                 matrix_in_s;

`ifdef HID_MOUSE_ACC_EN
  logic [7:0]                 dx_q, dx_d;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {a[7], a} + {b[7], b};
    if (sum[8] != sum[7]) begin
      sat_add = sum[8] ? 8'h80 : 8'h7F;
    end else begin
      sat_add = sum[7:0];
    end
  endfunction
`else
  logic unused_ack_s;
  assign unused_ack_s = mouse_ack;
`endif

  // Row sense: AND of the rows of every column currently driven low.
  always_comb begin
    matrix_in_s = 8'hFF;
    for (int c = 0; c < 8; c++) begin
      matrix_in_s = matrix_in_s & (keyboard_matrix_out[c] ? 8'hFF : keyboard_q[c]);
    end
  end

  // Next-state decode of the MCU byte stream and the DB9 change monitor.
  always_comb begin
    state_d        = state_q;
    command_d      = command_q;
    device_d       = device_q;
    data_out_d     = data_out_q;
    keyboard_d     = keyboard_q;
    joystick_d     = joystick_q;
    numpad_d       = numpad_q;
    mod_key_d      = mod_key_q;
    key_restore_d  = key_restore_q;
    tape_play_d    = tape_play_q;
    mouse_btns_d   = mouse_btns_q;
    mouse_strobe_d = 1'b0;
    irq_d          = irq_q & ~iack;
    irq_enable_d   = irq_enable_q;
    pending_d      = pending_q;
    db9_d          = db9_port;
    change_s       = 2'b00;
`ifdef HID_MOUSE_ACC_EN
    dx_d           = dx_q;
    mouse_x_d      = mouse_ack ? 8'h00 : mouse_x_q;
    mouse_y_d      = mouse_ack ? 8'h00 : mouse_y_q;
`else
    mouse_x_d      = mouse_x_q;
    mouse_y_d      = mouse_y_q;
`endif

    for (int p = 0; p < DB9_PORTS; p++) begin
      change_s[p] = irq_enable_q && (db9_port[6*p +: 6] != db9_q[6*p +: 6]);
    end

    if (data_in_strobe && data_in_start) begin
      state_d   = 4'd1;
      command_d = data_in;
      // The keyboard command byte is itself a key event, like every byte of its frame.
      if (data_in == CMD_KEYBOARD) begin
        keyboard_d[data_in[2:0]][data_in[5:3]] = data_in[7];
      end else begin
        keyboard_d = keyboard_q;
      end
    end else if (data_in_strobe && (state_q != 4'd0)) begin
      state_d = (state_q == 4'd15) ? 4'd15 : state_q + 4'd1;
      case (command_q)
        CMD_STATUS: begin
          case (state_q)
            4'd1:    data_out_d = 8'h5C;
            4'd2:    data_out_d = 8'h42;
            4'd3:    data_out_d = 8'(NUM_JOY);
            4'd4:    data_out_d = 8'(DB9_PORTS);
            default: data_out_d = data_out_q;
          endcase
        end
        CMD_KEYBOARD: begin
          keyboard_d[data_in[2:0]][data_in[5:3]] = data_in[7];
        end
        CMD_MOUSE: begin
          case (state_q)
            4'd1: mouse_btns_d = data_in[1:0];
`ifdef HID_MOUSE_ACC_EN
            4'd2: dx_d = data_in;
            4'd3: begin
              mouse_x_d      = sat_add(mouse_x_d, dx_q);
              mouse_y_d      = sat_add(mouse_y_d, data_in);
              mouse_strobe_d = 1'b1;
            end
`else
            4'd2: mouse_x_d = data_in;
            4'd3: begin
              mouse_y_d      = data_in;
              mouse_strobe_d = 1'b1;
            end
`endif
            default: mouse_btns_d = mouse_btns_q;
          endcase
        end
        CMD_JOYSTICK: begin
          case (state_q)
            4'd1: device_d = data_in;
            4'd2: begin
              for (int j = 0; j < NUM_JOY; j++) begin
                if (device_q == 8'(j)) begin
                  joystick_d[8*j +: 8] = data_in;
                end else begin
                  joystick_d[8*j +: 8] = joystick_d[8*j +: 8];
                end
              end
              if (device_q == DEV_NUMPAD) begin
                numpad_d      = data_in;
                mod_key_d     = data_in[5];
                key_restore_d = data_in[6];
                tape_play_d   = data_in[7];
              end else begin
                numpad_d      = numpad_q;
              end
            end
            default: device_d = device_q;
          endcase
        end
        CMD_DB9: begin
          if (state_q == 4'd1) begin
            data_out_d   = {6'b000000, pending_q};
            irq_enable_d = 1'b1;
            pending_d    = 2'b00;
          end else begin
            for (int p = 0; p < DB9_PORTS; p++) begin
              if (state_q == 4'(p + 2)) begin
                data_out_d = {2'b00, db9_port[6*p +: 6]};
              end else begin
                data_out_d = data_out_d;
              end
            end
          end
        end
        default: data_out_d = data_out_q;
      endcase
    end else begin
      state_d = state_q;
    end

    // A fresh change outranks both iack and a same-cycle pending clear.
    if (change_s != 2'b00) begin
      pending_d    = pending_d | change_s;
      irq_d        = 1'b1;
      irq_enable_d = 1'b0;
    end else begin
      pending_d    = pending_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= 4'd0;
      command_q      <= 8'h00;
      device_q       <= 8'h00;
      data_out_q     <= 8'h00;
      keyboard_q     <= {8{8'hFF}};
      joystick_q     <= '0;
      numpad_q       <= 8'h00;
      mod_key_q      <= 1'b0;
      key_restore_q  <= 1'b0;
      tape_play_q    <= 1'b0;
      mouse_btns_q   <= 2'b00;
      mouse_x_q      <= 8'h00;
      mouse_y_q      <= 8'h00;
      mouse_strobe_q <= 1'b0;
      irq_q          <= 1'b0;
      irq_enable_q   <= 1'b0;
      pending_q      <= 2'b00;
      db9_q          <= db9_port;
`ifdef HID_MOUSE_ACC_EN
      dx_q           <= 8'h00;
`endif
    end else begin
      state_q        <= state_d;
      command_q      <= command_d;
      device_q       <= device_d;
      data_out_q     <= data_out_d;
      keyboard_q     <= keyboard_d;
      joystick_q     <= joystick_d;
      numpad_q       <= numpad_d;
      mod_key_q      <= mod_key_d;
      key_restore_q  <= key_restore_d;
      tape_play_q    <= tape_play_d;
      mouse_btns_q   <= mouse_btns_d;
      mouse_x_q      <= mouse_x_d;
      mouse_y_q      <= mouse_y_d;
      mouse_strobe_q <= mouse_strobe_d;
      irq_q          <= irq_d;
      irq_enable_q   <= irq_enable_d;
      pending_q      <= pending_d;
      db9_q          <= db9_d;
`ifdef HID_MOUSE_ACC_EN
      dx_q           <= dx_d;
`endif
    end
  end

  assign data_out           = data_out_q;
  assign irq                = irq_q;
  assign joystick           = joystick_q;
  assign numpad             = numpad_q;
  assign mod_key            = mod_key_q;
  assign key_restore        = key_restore_q;
  assign tape_play          = tape_play_q;
  assign keyboard_matrix_in = matrix_in_s;
  assign mouse_btns         = mouse_btns_q;
  assign mouse_x            = mouse_x_q;
  assign mouse_y            = mouse_y_q;
  assign mouse_strobe       = mouse_strobe_q;

endmodule

// File: tb/tb_hid_multi.sv
// Directed self-checking bench for hid_multi (NUM_JOY=2, DB9_PORTS=2).
module tb_hid_multi;
  localparam int NJ = 2;
  localparam int NP = 2;
`ifdef HID_MOUSE_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_in_strobe = 1'b0, data_in_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [6*NP-1:0] db9_port = '0;
  logic irq, iack = 1'b0;
  logic [8*NJ-1:0] joystick;
  logic [7:0] numpad;
  logic mod_key, key_restore, tape_play;
  logic [7:0] kmo = 8'hFF, kmi;
  logic [1:0] mouse_btns;
  logic [7:0] mouse_x, mouse_y;
  logic mouse_strobe, mouse_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  hid_multi #(.NUM_JOY(NJ), .DB9_PORTS(NP)) dut (
    .clk(clk), .reset(reset),
    .data_in_strobe(data_in_strobe), .data_in_start(data_in_start), .data_in(data_in),
    .data_out(data_out), .db9_port(db9_port), .irq(irq), .iack(iack),
    .joystick(joystick), .numpad(numpad), .mod_key(mod_key),
    .key_restore(key_restore), .tape_play(tape_play),
    .keyboard_matrix_out(kmo), .keyboard_matrix_in(kmi),
    .mouse_btns(mouse_btns), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .mouse_strobe(mouse_strobe), .mouse_ack(mouse_ack)
  );

  always #5 clk = ~clk;

  task automatic send(input logic st, input logic [7:0] d);
    @(negedge clk);
    data_in_strobe = 1'b1; data_in_start = st; data_in = d;
    @(negedge clk);
    data_in_strobe = 1'b0; data_in_start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    kmo = 8'h00; #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data_out got %h want 00", data_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq); end
    checks++; if (joystick !== 16'h0000) begin errors++; $display("FAIL rst_joy got %h want 0000", joystick); end
    checks++; if ({numpad, mod_key, key_restore, tape_play} !== 11'd0) begin errors++; $display("FAIL rst_numpad got %h %b%b%b want 0", numpad, mod_key, key_restore, tape_play); end
    checks++; if ({mouse_btns, mouse_x, mouse_y, mouse_strobe} !== 19'd0) begin errors++; $display("FAIL rst_mouse got %b %h %h %b want 0", mouse_btns, mouse_x, mouse_y, mouse_strobe); end
    checks++; if (kmi !== 8'hFF) begin errors++; $display("FAIL rst_kmi got %h want FF", kmi); end
    kmo = 8'hFF;
  endtask

  task automatic test_status();
    logic [7:0] exp_seq [5];
    exp_seq[0] = 8'h5C; exp_seq[1] = 8'h42; exp_seq[2] = 8'h02; exp_seq[3] = 8'h02; exp_seq[4] = 8'h02;
    send(1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 8'hA5);
      checks++; if (data_out !== exp_seq[i]) begin errors++; $display("FAIL status_%0d got %h want %h", i, data_out, exp_seq[i]); end
    end
  endtask

  task automatic test_keyboard();
    send(1'b1, 8'h01);
    send(1'b0, 8'h8A);
    send(1'b0, 8'h0A);
    kmo = 8'hFD; #1;
    checks++; if (kmi !== 8'hFE) begin errors++; $display("FAIL kbd_col1 got %h want FE", kmi); end
    kmo = 8'hFB; #1;
    checks++; if (kmi !== 8'hFD) begin errors++; $display("FAIL kbd_col2 got %h want FD", kmi); end
    kmo = 8'hF9; #1;
    checks++; if (kmi !== 8'hFC) begin errors++; $display("FAIL kbd_col12 got %h want FC", kmi); end
    kmo = 8'hFF; #1;
    checks++; if (kmi !== 8'hFF) begin errors++; $display("FAIL kbd_none got %h want FF", kmi); end
    send(1'b0, 8'h8A);
    kmo = 8'hFB; #1;
    checks++; if (kmi !== 8'hFF) begin errors++; $display("FAIL kbd_release got %h want FF", kmi); end
    kmo = 8'hFF;
  endtask

  task automatic test_joystick();
    send(1'b1, 8'h03); send(1'b0, 8'h01); send(1'b0, 8'h1F);
    checks++; if (joystick !== 16'h1F00) begin errors++; $display("FAIL joy1 got %h want 1F00", joystick); end
    send(1'b0, 8'h33);
    checks++; if (joystick !== 16'h1F00) begin errors++; $display("FAIL joy_extra got %h want 1F00", joystick); end
    send(1'b1, 8'h03); send(1'b0, 8'h80); send(1'b0, 8'hE0);
    checks++; if ({numpad, mod_key, key_restore, tape_play} !== {8'hE0, 3'b111}) begin errors++; $display("FAIL numpad got %h %b%b%b want E0 111", numpad, mod_key, key_restore, tape_play); end
    send(1'b1, 8'h03); send(1'b0, 8'h05); send(1'b0, 8'hAA);
    checks++; if (joystick !== 16'h1F00 || numpad !== 8'hE0) begin errors++; $display("FAIL joy_baddev got %h %h want 1F00 E0", joystick, numpad); end
  endtask

  task automatic test_mouse();
    send(1'b1, 8'h02); send(1'b0, 8'h01); send(1'b0, 8'h70); send(1'b0, 8'h05);
    checks++; if (mouse_strobe !== 1'b1) begin errors++; $display("FAIL mstrobe1 got %b want 1", mouse_strobe); end
    checks++; if ({mouse_btns, mouse_x, mouse_y} !== {2'b01, 8'h70, 8'h05}) begin errors++; $display("FAIL mouse1 got %b %h %h want 01 70 05", mouse_btns, mouse_x, mouse_y); end
    @(negedge clk);
    checks++; if (mouse_strobe !== 1'b0) begin errors++; $display("FAIL mstrobe1_end got %b want 0", mouse_strobe); end
    send(1'b1, 8'h02); send(1'b0, 8'h02); send(1'b0, 8'h70); send(1'b0, 8'hFB);
    checks++; if (mouse_strobe !== 1'b1) begin errors++; $display("FAIL mstrobe2 got %b want 1", mouse_strobe); end
    checks++; if ({mouse_btns, mouse_x, mouse_y} !== (ACC ? {2'b10, 8'h7F, 8'h00} : {2'b10, 8'h70, 8'hFB})) begin errors++; $display("FAIL mouse2 got %b %h %h", mouse_btns, mouse_x, mouse_y); end
    @(negedge clk);
    checks++; if (mouse_strobe !== 1'b0) begin errors++; $display("FAIL mstrobe2_end got %b want 0", mouse_strobe); end
    mouse_ack = 1'b1; @(negedge clk); mouse_ack = 1'b0;
    checks++; if ({mouse_x, mouse_y} !== (ACC ? 16'h0000 : 16'h70FB)) begin errors++; $display("FAIL mouse_ack got %h %h", mouse_x, mouse_y); end
  endtask

  task automatic test_db9();
    db9_port = {6'h00, 6'h15};
    send(1'b1, 8'h04); send(1'b0, 8'h00);
    checks++; if (data_out !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL db9_enable got %h irq %b want 00 0", data_out, irq); end
    db9_port[6] = 1'b1; @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL db9_irq got %b want 1", irq); end
    iack = 1'b1; @(negedge clk); iack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL db9_iack got %b want 0", irq); end
    send(1'b1, 8'h04);
    send(1'b0, 8'h00);
    checks++; if (data_out !== 8'h02) begin errors++; $display("FAIL db9_pending got %h want 02", data_out); end
    send(1'b0, 8'h00);
    checks++; if (data_out !== 8'h15) begin errors++; $display("FAIL db9_port0 got %h want 15", data_out); end
    send(1'b0, 8'h00);
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL db9_port1 got %h want 01", data_out); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL db9_quiet got %b want 0", irq); end
    iack = 1'b1; db9_port[1] = 1'b1; @(negedge clk); iack = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL db9_iack_vs_change got %b want 1", irq); end
    send(1'b1, 8'h04); send(1'b0, 8'h00);
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL db9_pending0 got %h want 01", data_out); end
  endtask

  task automatic test_reset_midframe();
    send(1'b1, 8'h03); send(1'b0, 8'h00);
    pulse_reset();
    send(1'b0, 8'h55); send(1'b0, 8'h66);
    checks++; if (joystick !== 16'h0000 || data_out !== 8'h00) begin errors++; $display("FAIL rst_midframe got %h %h want 0000 00", joystick, data_out); end
  endtask

  task automatic test_abort_and_unknown();
    send(1'b1, 8'h03); send(1'b0, 8'h00);
    send(1'b1, 8'h00); send(1'b0, 8'h12);
    checks++; if (data_out !== 8'h5C || joystick !== 16'h0000) begin errors++; $display("FAIL abort got %h %h want 5C 0000", data_out, joystick); end
    send(1'b1, 8'h07); send(1'b0, 8'h80); send(1'b0, 8'hFF);
    checks++; if (data_out !== 8'h5C || joystick !== 16'h0000 || numpad !== 8'h00) begin errors++; $display("FAIL unknown got %h %h %h want 5C 0000 00", data_out, joystick, numpad); end
  endtask

  initial begin
    test_reset();
    test_status();
    test_keyboard();
    test_joystick();
    test_mouse();
    test_db9();
    test_reset_midframe();
    test_abort_and_unknown();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
